// File: rtl/md_pkg.sv
// Shared types and helpers for the iterative HI/LO multiply/divide unit.
package md_pkg;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // Number of RUN cycles: one per quotient bit, or one per MUL_STEP multiplier bits.
  function automatic int unsigned md_steps(input md_op_t op,
                                           input int unsigned width,
                                           input int unsigned mul_step);
    return (op == MD_DIV) ? width : (width / mul_step);
  endfunction

endpackage

// File: rtl/md_div_step.sv
// Single restoring-division step on unsigned magnitudes.
module md_div_step
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem_c,
  output logic             o_qbit_c
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Partial remainder stays below the divisor, so the top diff bit is a clean borrow flag.
  always_comb begin
    w_shift  = {i_rem, i_bit};
    w_diff   = w_shift - {1'b0, i_divisor};
    o_qbit_c = ~w_diff[WIDTH];
    o_rem_c  = o_qbit_c ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/md_iter_unit.sv
// Iterative signed/unsigned multiply and divide for the HI/LO path, with
// flush cancel and a valid/ack result handshake.
module md_iter_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned PSUM_W = WIDTH + MUL_STEP;
  localparam int unsigned PROD_W = 2 * WIDTH;

  md_state_t        r_state;
  md_state_t        w_state_nx;
  logic             w_load;

  md_op_t           r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_a;
  logic             r_neg_main;
  logic             r_neg_rem;
  logic             r_div0;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_last;

  logic [MUL_STEP-1:0] w_mdig;
  logic [PSUM_W-1:0]   w_psum;
  logic [WIDTH-1:0]    w_mul_acc_nx;
  logic [WIDTH-1:0]    w_mul_q_nx;
  logic [PROD_W-1:0]   w_prod;
  logic [PROD_W-1:0]   w_prod_fix;

  logic [WIDTH-1:0] w_div_rem;
  logic             w_div_qbit;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic [WIDTH-1:0] w_hi_fix;
  logic [WIDTH-1:0] w_lo_fix;

  md_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem     (r_acc),
    .i_divisor (r_mcand),
    .i_bit     (r_q[WIDTH-1]),
    .o_rem_c   (w_div_rem),
    .o_qbit_c  (w_div_qbit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next state; cancel overrides every transition and drops a coincident start
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_last     = (r_cnt == CNT_W'(1));
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = ST_RUN;
          w_load     = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_last) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (ack) begin
          w_state_nx = start ? ST_RUN : ST_IDLE;
          w_load     = start;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (cancel) begin
      w_state_nx = ST_IDLE;
      w_load     = 1'b0;
    end
  end

  // Operand magnitudes and one multiply/divide step with final sign fix-up
  always_comb begin
    w_a_neg = is_signed & a[WIDTH-1];
    w_b_neg = is_signed & b[WIDTH-1];
    w_a_mag = w_a_neg ? (~a + WIDTH'(1)) : a;
    w_b_mag = w_b_neg ? (~b + WIDTH'(1)) : b;

    w_mdig       = r_q[MUL_STEP-1:0];
    w_psum       = PSUM_W'(r_acc) + PSUM_W'(r_mcand) * PSUM_W'(w_mdig);
    w_mul_acc_nx = w_psum[PSUM_W-1:MUL_STEP];
    w_mul_q_nx   = {w_psum[MUL_STEP-1:0], r_q[WIDTH-1:MUL_STEP]};
    w_prod       = {w_mul_acc_nx, w_mul_q_nx};
    w_prod_fix   = r_neg_main ? (~w_prod + PROD_W'(1)) : w_prod;

    w_quo    = {r_q[WIDTH-2:0], w_div_qbit};
    w_div_lo = r_div0 ? {WIDTH{1'b1}}
                      : (r_neg_main ? (~w_quo + WIDTH'(1)) : w_quo);
    w_div_hi = r_div0 ? r_a
                      : (r_neg_rem ? (~w_div_rem + WIDTH'(1)) : w_div_rem);

    if (r_op == MD_DIV) begin
      w_acc_nx = w_div_rem;
      w_q_nx   = w_quo;
      w_hi_fix = w_div_hi;
      w_lo_fix = w_div_lo;
    end else begin
      w_acc_nx = w_mul_acc_nx;
      w_q_nx   = w_mul_q_nx;
      w_hi_fix = w_prod_fix[PROD_W-1:WIDTH];
      w_lo_fix = w_prod_fix[WIDTH-1:0];
    end
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= MD_MUL;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_mcand    <= '0;
      r_a        <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div0     <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_busy  <= (w_state_nx == ST_RUN);
      r_valid <= (w_state_nx == ST_DONE);
      if (w_load) begin
        r_op       <= md_op_t'(op);
        r_cnt      <= CNT_W'(md_steps(md_op_t'(op), WIDTH, MUL_STEP));
        r_acc      <= '0;
        r_q        <= op ? w_a_mag : w_b_mag;
        r_mcand    <= op ? w_b_mag : w_a_mag;
        r_a        <= a;
        r_neg_main <= w_a_neg ^ w_b_neg;
        r_neg_rem  <= w_a_neg;
        r_div0     <= (b == '0);
      end else if ((r_state == ST_RUN) && !cancel) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_acc <= w_acc_nx;
        r_q   <= w_q_nx;
        if (w_last) begin
          r_hi <= w_hi_fix;
          r_lo <= w_lo_fix;
        end
      end
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed bench for md_iter_unit (WIDTH=32, MUL_STEP=2) with hand-computed results.
module tb_md_iter_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         ack;
  logic         busy;
  logic         valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_mis = 0;

  md_iter_unit #(
    .WIDTH    (W),
    .MUL_STEP (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .ack       (ack),
    .busy      (busy),
    .valid     (valid),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an operation for exactly one rising edge.
  task automatic launch(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start     = 1'b1;
    op        = o;
    is_signed = s;
    a         = x;
    b         = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles from the current one, then check the held result.
  task automatic wait_done(input string tag, input int n, input logic [W-1:0] eh, input logic [W-1:0] el);
    int cnt = 0;
    int vb  = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (valid) vb++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(cnt), 64'(n));
    chk({tag, "_bv"}, 64'(vb), 64'(0));
    chk({tag, "_valid"}, 64'(valid), 64'(1));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  task automatic take(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({tag, "_idle_v"}, 64'(valid), 64'(0));
    chk({tag, "_idle_b"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op = 1'b0; is_signed = 1'b0;
    a = '0; b = '0; cancel = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));

    launch(1'b0, 1'b0, 32'd7, 32'd6);
    wait_done("mul_u_7x6", 16, 32'h0, 32'd42);
    take("mul_u_7x6");

    launch(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_s_m1xm1", 16, 32'h0, 32'h1);
    take("mul_s_m1xm1");

    launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_u_max", 16, 32'hFFFF_FFFE, 32'h0000_0001);
    take("mul_u_max");

    launch(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
    wait_done("mul_s_m3x5", 16, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    take("mul_s_m3x5");

    launch(1'b1, 1'b0, 32'd100, 32'd7);
    wait_done("div_u_100_7", 32, 32'd2, 32'd14);
    take("div_u_100_7");

    launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_s_m7_2", 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    take("div_s_m7_2");

    launch(1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_done("div_s_100_m7", 32, 32'd2, 32'hFFFF_FFF2);
    take("div_s_100_m7");

    launch(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_s_ovf", 32, 32'h0, 32'h8000_0000);
    take("div_s_ovf");

    launch(1'b1, 1'b0, 32'h1234, 32'h0);
    wait_done("div_u_by0", 32, 32'h1234, 32'hFFFF_FFFF);
    take("div_u_by0");

    launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0);
    wait_done("div_s_by0", 32, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    take("div_s_by0");

    // Cancel in the 10th busy cycle of a divide, with a start in the same cycle.
    launch(1'b1, 1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    chk("cancel_busy10", 64'(busy), 64'(1));
    cancel = 1'b1; start = 1'b1; op = 1'b0; a = 32'd7; b = 32'd6;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    chk("cancel_busy", 64'(busy), 64'(0));
    chk("cancel_valid", 64'(valid), 64'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || valid) seen++;
    end
    chk("cancel_quiet", 64'(seen), 64'(0));

    // Hold ack low with ignored start pulses, then ack+start back-to-back.
    launch(1'b0, 1'b0, 32'd1000, 32'd1000);
    wait_done("hs_mul", 16, 32'h0, 32'h000F_4240);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd5; b = 32'd1;
      @(negedge clk);
      chk("hold_valid", 64'(valid), 64'(1));
      chk("hold_busy", 64'(busy), 64'(0));
      chk("hold_hi", 64'(hi), 64'(0));
      chk("hold_lo", 64'(lo), 64'h000F_4240);
    end
    start = 1'b1; ack = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_valid", 64'(valid), 64'(0));
    wait_done("b2b_div", 32, 32'd2, 32'd14);
    take("b2b_div");

    // Reset in the middle of a run.
    launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_valid", 64'(valid), 64'(0));
    chk("mrst_hi", 64'(hi), 64'(0));
    chk("mrst_lo", 64'(lo), 64'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || valid) seen++;
    end
    chk("mrst_quiet", 64'(seen), 64'(0));

    launch(1'b0, 1'b0, 32'd7, 32'd6);
    wait_done("post_rst_mul", 16, 32'h0, 32'd42);
    take("post_rst_mul");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
